// File: rtl/frame_block_fetch_pkg.sv
// Shared types and defaults for the block fetch engine: FSM state encoding,
// default frame/pixel/block geometry and the block packing index helper.
package frame_block_fetch_pkg;

  localparam int unsigned FrameWDef = 320;
  localparam int unsigned FrameHDef = 240;
  localparam int unsigned PixWDef   = 8;
  localparam int unsigned BlkDef    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  // LSB position of raster pixel idx inside the packed block; pixel 0 sits in the MSBs.
  function automatic int unsigned blk_pix_lsb(int unsigned idx, int unsigned npix,
                                              int unsigned pix_w);
    return (npix - 1 - idx) * pix_w;
  endfunction

endpackage

// File: rtl/frame_block_fetch_ram.sv
// Frame store: one write port, one registered read port (1-cycle latency).
// A simultaneous read and write of the same word returns the old contents.
module frame_ram #(
  parameter int unsigned DEPTH = 76800,
  parameter int unsigned PIX_W = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write commit and registered read; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_block_fetch.sv
// Block fetch engine: on an accepted request, reads a BLK x BLK window from the
// frame store in raster order and presents it packed (pixel (0,0) in the MSBs)
// until the consumer takes it.
// Build option BLK_EDGE_CLAMP_EN: out-of-frame coordinates replicate the frame
// edge; without it they read as zero (no RAM access). Latency is identical.
module frame_block_fetch
  import frame_block_fetch_pkg::*;
#(
  parameter int unsigned FRAME_W = FrameWDef,
  parameter int unsigned FRAME_H = FrameHDef,
  parameter int unsigned PIX_W   = PixWDef,
  parameter int unsigned BLK     = BlkDef,
  localparam int unsigned XW     = $clog2(FRAME_W),
  localparam int unsigned YW     = $clog2(FRAME_H),
  localparam int unsigned AW     = $clog2(FRAME_W * FRAME_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [PIX_W-1:0]         wr_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XW-1:0]            req_x,
  input  logic [YW-1:0]            req_y,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [BLK*BLK*PIX_W-1:0] blk_data,
  output logic                     busy
);

  localparam int unsigned NPix = BLK * BLK;
  localparam int unsigned CW   = $clog2(NPix + 1);
  // Extended coordinate widths so base + BLK-1 never wraps.
  localparam int unsigned XEW  = XW + $clog2(BLK + 1);
  localparam int unsigned YEW  = YW + $clog2(BLK + 1);

  state_e                   state_q, state_d;
  logic                     init_q;
  logic [XW-1:0]            bx_q;
  logic [YW-1:0]            by_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     cap_vld_q;
  logic [CW-1:0]            cap_idx_q;
  logic                     cap_zero_q;
  logic [BLK*BLK*PIX_W-1:0] blk_q;

  logic                     accept;
  logic                     issue;
  logic                     last_cap;
  logic [CW-1:0]            row_off, col_off;
  logic [XEW-1:0]           pix_x;
  logic [YEW-1:0]           pix_y;
  logic [XW-1:0]            x_eff;
  logic [YW-1:0]            y_eff;
  logic                     oof;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  logic [PIX_W-1:0]         rd_data;

  // init_q keeps req_ready low until the first edge after reset is released.
  assign req_ready = (state_q == StIdle) && init_q;
  assign accept    = req_valid && req_ready;
  assign issue     = (state_q == StFetch) && (cnt_q < CW'(NPix));
  assign last_cap  = cap_vld_q && (cap_idx_q == CW'(NPix - 1));
  assign blk_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign blk_data  = blk_q;

  // Pixel coordinate and RAM address for the read issued this cycle.
  always_comb begin
    row_off = cnt_q / CW'(BLK);
    col_off = cnt_q % CW'(BLK);
    pix_x   = XEW'(bx_q) + XEW'(col_off);
    pix_y   = YEW'(by_q) + YEW'(row_off);
`ifdef BLK_EDGE_CLAMP_EN
    x_eff   = (pix_x >= XEW'(FRAME_W)) ? XW'(FRAME_W - 1) : pix_x[XW-1:0];
    y_eff   = (pix_y >= YEW'(FRAME_H)) ? YW'(FRAME_H - 1) : pix_y[YW-1:0];
    oof     = 1'b0;
`else
    x_eff   = pix_x[XW-1:0];
    y_eff   = pix_y[YW-1:0];
    oof     = (pix_x >= XEW'(FRAME_W)) || (pix_y >= YEW'(FRAME_H));
`endif
    rd_en   = issue && !oof;
    rd_addr = AW'(y_eff) * AW'(FRAME_W) + AW'(x_eff);
  end

  // Next-state logic: one read per FETCH cycle, HOLD once the last pixel lands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (issue) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (last_cap) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (blk_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request capture and block assembly; read data lands one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      init_q     <= 1'b0;
      bx_q       <= '0;
      by_q       <= '0;
      cnt_q      <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_zero_q <= 1'b0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_q     <= 1'b1;
      if (accept) begin
        bx_q <= req_x;
        by_q <= req_y;
      end
      cap_vld_q  <= issue;
      cap_idx_q  <= cnt_q;
      cap_zero_q <= oof;
      if (cap_vld_q) begin
        blk_q[blk_pix_lsb(32'(cap_idx_q), NPix, PIX_W) +: PIX_W] <=
            cap_zero_q ? '0 : rd_data;
      end
    end
  end

  frame_ram #(
    .DEPTH (FRAME_W * FRAME_H),
    .PIX_W (PIX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_frame_block_fetch.sv
// Directed bench for frame_block_fetch at default geometry (320x240, 8b, 4x4).
// RAM is preloaded (only the windows used) with pixel[a] = a mod 256.
module tb_frame_block_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [16:0]  wr_addr;
  logic [7:0]   wr_data;
  logic         req_valid;
  logic         req_ready;
  logic [8:0]   req_x;
  logic [7:0]   req_y;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  frame_block_fetch u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic wr_px(input int addr, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 17'(addr);
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic issue_req(input int x, input int y);
    int n = 0;
    req_valid = 1'b1;
    req_x     = 9'(x);
    req_y     = 8'(y);
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check_eq("req_ready_timeout", 128'(req_ready), 128'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!blk_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  logic [127:0] exp_00;
  logic [127:0] exp_40;
  logic [127:0] exp_corner;
  logic [127:0] snap;
  int           lat;
  int           seen;

  initial begin
    exp_00 = 128'h00010203_40414243_80818283_C0C1C2C3;
    exp_40 = 128'h04050607_44454647_84858687_C4C5C6C7;
`ifdef BLK_EDGE_CLAMP_EN
    exp_corner = 128'hBEBFBFBF_FEFFFFFF_FEFFFFFF_FEFFFFFF;
`else
    exp_corner = 128'hBEBF0000_FEFF0000_00000000_00000000;
`endif
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    blk_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 128'(req_ready), 128'(0));
    check_eq("rst_blk_valid", 128'(blk_valid), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_blk_data", blk_data, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_req_ready", 128'(req_ready), 128'(1));

    // Preload the windows used below
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) wr_px(r * 320 + c, 8'(r * 320 + c));
    for (int r = 236; r < 240; r++)
      for (int c = 312; c < 320; c++) wr_px(r * 320 + c, 8'(r * 320 + c));

    // Basic block at (0,0)
    issue_req(0, 0);
    check_eq("fetch_busy", 128'(busy), 128'(1));
    wait_valid(lat);
    check_eq("lat_00", 128'(lat), 128'(17));
    check_eq("data_00", blk_data, exp_00);
    consume();
    check_eq("idle_after_hold", 128'(req_ready), 128'(1));

    // Hold with blk_ready low while a second request is stalled
    issue_req(0, 0);
    wait_valid(lat);
    check_eq("lat_hold", 128'(lat), 128'(17));
    snap = blk_data;
    check_eq("data_hold", snap, exp_00);
    req_valid = 1'b1;
    req_x     = 9'd4;
    req_y     = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 128'(blk_valid), 128'(1));
      check_eq("hold_data", blk_data, exp_00);
      check_eq("hold_req_ready", 128'(req_ready), 128'(0));
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    check_eq("release_valid", 128'(blk_valid), 128'(0));
    check_eq("release_req_ready", 128'(req_ready), 128'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_x     = 9'd100;
    req_y     = 8'd50;
    check_eq("b2b_accepted", 128'(busy), 128'(1));
    wait_valid(lat);
    check_eq("lat_b2b", 128'(lat), 128'(17));
    check_eq("data_40", blk_data, exp_40);
    consume();

    // Bottom-right corner, partially out of frame
    issue_req(318, 238);
    wait_valid(lat);
    check_eq("lat_corner", 128'(lat), 128'(17));
    check_eq("data_corner", blk_data, exp_corner);
    consume();

    // Reset in the middle of FETCH aborts the block
    issue_req(0, 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 128'(busy), 128'(0));
    check_eq("abort_req_ready", 128'(req_ready), 128'(0));
    check_eq("abort_blk_data", blk_data, 128'(0));
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (blk_valid) seen = 1;
    end
    check_eq("abort_no_valid", 128'(seen), 128'(0));
    issue_req(0, 0);
    wait_valid(lat);
    check_eq("lat_after_abort", 128'(lat), 128'(17));
    check_eq("data_after_abort", blk_data, exp_00);
    consume();

    // Write visibility and read-before-write on address 1
    wr_px(0, 8'hAA);
    issue_req(0, 0);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_addr = 17'd1;
    wr_data = 8'h55;
    @(posedge clk); #1;
    wr_en   = 1'b0;
    wait_valid(lat);
    check_eq("lat_rbw", 128'(lat), 128'(15));
    check_eq("wr_px0", 128'(blk_data[127:120]), 128'(8'hAA));
    check_eq("rbw_old_px1", 128'(blk_data[119:112]), 128'(8'h01));
    consume();
    issue_req(0, 0);
    wait_valid(lat);
    check_eq("wr_px1_new", 128'(blk_data[127:112]), 128'(16'hAA55));
    consume();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
